reg_write_scoreboard: RTL and testbench
=======================================

Name: reg_write_scoreboard

Overview:
- Parametrised successor to the register-file write decoder.
- Decodes the writeback destination ID into a one-hot, write-enable-gated wordline bus for NUM_REGS registers.
- Adds a per-register outstanding-write scoreboard: issue increments, writeback decrements.
- Drives read-after-write stall for two source operands and sits between the decode/issue stage and the register file.

Parameters:
ID_W, 4, register ID width; NUM_REGS = 2**ID_W.
CNT_W, 2, per-register outstanding-write counter width; saturation value is 2**CNT_W-1.
ZERO_REG, 1, 1 = register 0 is hardwired (never wordlined, never tracked); 0 = register 0 is ordinary.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
iss_en  input  1  issue of an instruction that will write iss_id
iss_id  input  ID_W  destination register of issuing instruction
iss_ready  output  1  counter of iss_id not saturated; issue is accepted only when high
wb_en  input  1  writeback strobe (replaces WriteReg)
wb_id  input  ID_W  writeback destination (replaces RegId)
wordline  output  NUM_REGS  one-hot write enable to register file
rd_id_a  input  ID_W  source operand A
rd_id_b  input  ID_W  source operand B
stall  output  1  A or B has an outstanding write
pending  output  NUM_REGS  bit i = count[i] != 0 (registered state)
wb_err  output  1  sticky: writeback to a register with count 0

Behaviour:
- State: count[NUM_REGS] of CNT_W bits, plus wb_err flop.
- Reset (rst_n low at clk edge): all counts 0, wb_err 0. pending and stall read 0 the cycle after reset. wordline is combinational; it is 0 whenever wb_en is 0, including during reset.
- Wordline: wordline[i] = wb_en & (wb_id == i) & ~(ZERO_REG & i == 0).
  - Zero latency; exactly one bit high or all low.
  - wordline is not affected by count state; a writeback is always passed to the register file.
- Issue acceptance: accept = iss_en & iss_ready & ~(ZERO_REG & iss_id == 0).
  - iss_ready = (count[iss_id] != max), combinational.
  - iss_ready is forced 1 for hardwired register 0.
  - A rejected issue changes no state; upstream holds the instruction.
- Writeback decrement: dec = wb_en & count[wb_id] != 0 (register 0 excluded when ZERO_REG).
- Counter update per register i, at clk edge:
  - inc only: count+1.
  - dec only: count-1.
  - inc and dec same register, same cycle: count unchanged. Legal even at saturation, but iss_ready still gates using the pre-edge count, so an issue at max is rejected even if a writeback to that register is simultaneous.
  - Neither: hold.
  - No wrap-around in either direction: increment never occurs at max (gated by iss_ready), decrement never occurs at 0.
- wb_err: set when wb_en & count[wb_id] == 0 & not hardwired register 0. The count stays 0 (no underflow). Cleared only by reset.
- Stall, combinational: stall = busy(rd_id_a) | busy(rd_id_b).
  - busy(r) = count[r] != 0 & ~(wb_en & wb_id == r & count[r] == 1). A final writeback in the same cycle bypasses; the register file forwards write data.
  - busy(0) = 0 when ZERO_REG.
  - Same-cycle issue does not affect stall; the new count is visible from the next cycle.
- Reset mid-operation: all outstanding counts are discarded; the pipeline is assumed flushed by the same reset.

Test Plan:
- Reset, wb_en=0 -> wordline=0, pending=0, stall=0, wb_err=0. Then wb_en=1, wb_id=4'hB -> wordline=16'h0800 same cycle.
- ZERO_REG=1: wb_en=1, wb_id=0 -> wordline=0, wb_err stays 0. iss_en, iss_id=0 -> pending stays 0.
- Issue R5 three times (CNT_W=2) -> pending[5]=1, count 3, iss_ready=0 for iss_id=5. A fourth issue is rejected; 3 writebacks to R5 -> pending[5]=0.
- count[7]=1, rd_id_a=7 -> stall=1. The cycle with wb_en=1, wb_id=7 -> stall=0 and wordline=16'h0080; next cycle pending[7]=0.
- Simultaneous issue and wb to R3 with count[3]=2 -> count stays 2, pending[3]=1. Same at count=3 -> issue rejected, count becomes 2.
- wb_en=1, wb_id=9 with count[9]=0 -> wordline=16'h0200, wb_err=1 next cycle and held until rst_n=0. Assert reset with counts nonzero -> all pending=0 next cycle.

Source files
------------

// File: rtl/reg_write_scoreboard.sv
// Writeback wordline decoder with a per-register outstanding-write scoreboard.
// Issue increments a register's counter, writeback decrements it, and the counters drive the read-after-write stall.
module reg_write_scoreboard #(
   parameter int ID_W     = 4,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iss_en,
   input  logic [ID_W-1:0]      iss_id,
   output logic                 iss_ready,
   input  logic                 wb_en,
   input  logic [ID_W-1:0]      wb_id,
   output logic [(2**ID_W)-1:0] wordline,
   input  logic [ID_W-1:0]      rd_id_a,
   input  logic [ID_W-1:0]      rd_id_b,
   output logic                 stall,
   output logic [(2**ID_W)-1:0] pending,
   output logic                 wb_err
);

   localparam int               NUM_REGS = 2**ID_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               W_ZR     = (ZERO_REG != 0);

   logic [CNT_W-1:0]    r_count [NUM_REGS];
   logic                r_wb_err;

   logic                w_iss_zero;
   logic                w_wb_zero;
   logic                w_rda_zero;
   logic                w_rdb_zero;
   logic                w_accept;
   logic                w_dec;
   logic                w_wb_under;
   logic                w_busy_a;
   logic                w_busy_b;
   logic [NUM_REGS-1:0] w_inc_vec;
   logic [NUM_REGS-1:0] w_dec_vec;
   logic [NUM_REGS-1:0] w_wordline;
   logic [NUM_REGS-1:0] w_pending;

   assign w_iss_zero = W_ZR && (iss_id  == '0);
   assign w_wb_zero  = W_ZR && (wb_id   == '0);
   assign w_rda_zero = W_ZR && (rd_id_a == '0);
   assign w_rdb_zero = W_ZR && (rd_id_b == '0);

   // The hardwired register always reports ready so upstream never blocks on it.
   assign iss_ready  = w_iss_zero || (r_count[iss_id] != CNT_MAX);
   assign w_accept   = iss_en && iss_ready && !w_iss_zero;
   assign w_dec      = wb_en && !w_wb_zero && (r_count[wb_id] != '0);
   assign w_wb_under = wb_en && !w_wb_zero && (r_count[wb_id] == '0);

   // A final writeback in the same cycle releases the operand; the register file forwards the data.
   assign w_busy_a = !w_rda_zero && (r_count[rd_id_a] != '0) &&
                     !(wb_en && (wb_id == rd_id_a) && (r_count[rd_id_a] == CNT_ONE));
   assign w_busy_b = !w_rdb_zero && (r_count[rd_id_b] != '0) &&
                     !(wb_en && (wb_id == rd_id_b) && (r_count[rd_id_b] == CNT_ONE));
   assign stall    = w_busy_a || w_busy_b;

   always_comb begin
      w_wordline = '0;
      w_inc_vec  = '0;
      w_dec_vec  = '0;
      w_pending  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_wordline[i] = wb_en && (wb_id == ID_W'(i)) && !(W_ZR && (i == 0));
         w_inc_vec[i]  = w_accept && (iss_id == ID_W'(i));
         w_dec_vec[i]  = w_dec && (wb_id == ID_W'(i));
         w_pending[i]  = (r_count[i] != '0);
      end
   end

   assign wordline = w_wordline;
   assign pending  = w_pending;
   assign wb_err   = r_wb_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_count[i] <= '0;
         end
         r_wb_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
               r_count[i] <= r_count[i] + CNT_ONE;
            end else if (!w_inc_vec[i] && w_dec_vec[i]) begin
               r_count[i] <= r_count[i] - CNT_ONE;
            end
         end
         if (w_wb_under) begin
            r_wb_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Bench for reg_write_scoreboard: directed vector table, then random traffic against a counting model.
module tb_reg_write_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        iss_en;
   logic [3:0]  iss_id;
   logic        iss_ready;
   logic        wb_en;
   logic [3:0]  wb_id;
   logic [15:0] wordline;
   logic [3:0]  rd_id_a;
   logic [3:0]  rd_id_b;
   logic        stall;
   logic [15:0] pending;
   logic        wb_err;

   int checks;
   int errors;

   reg_write_scoreboard #(.ID_W(4), .CNT_W(2), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .iss_en(iss_en), .iss_id(iss_id), .iss_ready(iss_ready),
      .wb_en(wb_en), .wb_id(wb_id), .wordline(wordline),
      .rd_id_a(rd_id_a), .rd_id_b(rd_id_b), .stall(stall),
      .pending(pending), .wb_err(wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ie;
      logic [3:0]  iid;
      logic        we;
      logic [3:0]  wid;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [15:0] wl;
      logic        rdy;
      logic        st;
      logic [15:0] pend;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic ie, logic [3:0] iid, logic we, logic [3:0] wid,
                               logic [3:0] ra, logic [3:0] rb, logic [15:0] wl, logic rdy,
                               logic st, logic [15:0] pend, logic err);
      vec_t v;
      v.rst = rst; v.ie = ie; v.iid = iid; v.we = we; v.wid = wid; v.ra = ra; v.rb = rb;
      v.wl = wl; v.rdy = rdy; v.st = st; v.pend = pend; v.err = err;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   task automatic drive(logic rst, logic ie, logic [3:0] iid, logic we, logic [3:0] wid,
                        logic [3:0] ra, logic [3:0] rb);
      @(negedge clk);
      rst_n = rst; iss_en = ie; iss_id = iid; wb_en = we; wb_id = wid;
      rd_id_a = ra; rd_id_b = rb;
      #1;
   endtask

   // Reference model: outstanding-write counts as plain integers.
   int m_cnt[16];
   bit m_err;

   function automatic bit m_busy(int r, logic we, logic [3:0] wid);
      if (r == 0) return 1'b0;
      if (m_cnt[r] == 0) return 1'b0;
      if (we && int'(wid) == r && m_cnt[r] == 1) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      logic [15:0] e_wl;
      logic [15:0] e_pend;
      logic        e_rdy;
      logic        e_st;
      bit          acc;
      bit          dec;
      logic        r_rst, r_ie, r_we;
      logic [3:0]  r_iid, r_wid, r_ra, r_rb;

      checks = 0;
      errors = 0;
      rst_n = 1'b0; iss_en = 1'b0; iss_id = '0; wb_en = 1'b0; wb_id = '0;
      rd_id_a = '0; rd_id_b = '0;

      //          rst ie iid   we wid   ra    rb    wl        rdy st pend      err
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 4'h0, 1, 4'hB, 4'h0, 4'h0, 16'h0800, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 4'h5, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 4'h5, 0, 4'h0, 4'h5, 4'h0, 16'h0000, 1, 1, 16'h0020, 0));
      tbl.push_back(mk(1, 1, 4'h5, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0020, 0));
      tbl.push_back(mk(1, 1, 4'h5, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0, 16'h0020, 0));
      tbl.push_back(mk(1, 0, 4'h5, 1, 4'h5, 4'h0, 4'h0, 16'h0020, 0, 0, 16'h0020, 0));
      tbl.push_back(mk(1, 0, 4'h5, 1, 4'h5, 4'h0, 4'h0, 16'h0020, 1, 0, 16'h0020, 0));
      tbl.push_back(mk(1, 0, 4'h5, 1, 4'h5, 4'h5, 4'h0, 16'h0020, 1, 0, 16'h0020, 0));
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h5, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 4'h7, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h7, 4'h0, 16'h0000, 1, 1, 16'h0080, 0));
      tbl.push_back(mk(1, 0, 4'h0, 1, 4'h7, 4'h7, 4'h0, 16'h0080, 1, 0, 16'h0080, 0));
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h7, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 4'h3, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 4'h3, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0008, 0));
      tbl.push_back(mk(1, 1, 4'h3, 1, 4'h3, 4'h0, 4'h3, 16'h0008, 1, 1, 16'h0008, 0));
      tbl.push_back(mk(1, 1, 4'h3, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0008, 0));
      tbl.push_back(mk(1, 1, 4'h3, 1, 4'h3, 4'h0, 4'h0, 16'h0008, 0, 0, 16'h0008, 0));
      tbl.push_back(mk(1, 0, 4'h3, 1, 4'h3, 4'h0, 4'h3, 16'h0008, 1, 1, 16'h0008, 0));
      tbl.push_back(mk(1, 0, 4'h0, 1, 4'h9, 4'h0, 4'h0, 16'h0200, 1, 0, 16'h0008, 0));
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0008, 1));
      tbl.push_back(mk(1, 1, 4'hA, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0008, 1));
      tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 16'h0408, 1));
      tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 4'h3, 4'hA, 16'h0000, 1, 0, 16'h0000, 0));

      // Initial reset: only the combinational wordline is defined yet.
      drive(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
      chk("reset_wordline", 32'(wordline), 32'h0);
      drive(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0);

      foreach (tbl[k]) begin
         drive(tbl[k].rst, tbl[k].ie, tbl[k].iid, tbl[k].we, tbl[k].wid, tbl[k].ra, tbl[k].rb);
         chk($sformatf("tbl%0d_wordline", k), 32'(wordline), 32'(tbl[k].wl));
         chk($sformatf("tbl%0d_iss_ready", k), 32'(iss_ready), 32'(tbl[k].rdy));
         chk($sformatf("tbl%0d_stall", k), 32'(stall), 32'(tbl[k].st));
         chk($sformatf("tbl%0d_pending", k), 32'(pending), 32'(tbl[k].pend));
         chk($sformatf("tbl%0d_wb_err", k), 32'(wb_err), 32'(tbl[k].err));
      end

      // Hand sequence: wb_err stays set across many idle cycles until reset.
      drive(1, 0, 4'h0, 1, 4'h2, 4'h0, 4'h0);
      for (int c = 0; c < 5; c++) begin
         drive(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
         chk("err_sticky", 32'(wb_err), 32'h1);
      end
      drive(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
      drive(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
      chk("err_cleared", 32'(wb_err), 32'h0);

      // Random phase; state is all-zero at this point.
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r_rst = ($urandom_range(0, 199) != 0);
         r_ie  = ($urandom_range(0, 99) < 55);
         r_we  = ($urandom_range(0, 99) < 45);
         r_iid = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         r_wid = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         r_ra  = 4'($urandom_range(0, 5));
         r_rb  = 4'($urandom_range(0, 15));
         drive(r_rst, r_ie, r_iid, r_we, r_wid, r_ra, r_rb);

         e_wl = (r_we && r_wid != 4'h0) ? (16'h1 << r_wid) : 16'h0;
         e_rdy = (r_iid == 4'h0) ? 1'b1 : (m_cnt[r_iid] != 3);
         e_st = m_busy(int'(r_ra), r_we, r_wid) || m_busy(int'(r_rb), r_we, r_wid);
         e_pend = '0;
         for (int i = 0; i < 16; i++) e_pend[i] = (m_cnt[i] > 0);
         chk("rnd_wordline", 32'(wordline), 32'(e_wl));
         chk("rnd_iss_ready", 32'(iss_ready), 32'(e_rdy));
         chk("rnd_stall", 32'(stall), 32'(e_st));
         chk("rnd_pending", 32'(pending), 32'(e_pend));
         chk("rnd_wb_err", 32'(wb_err), 32'(m_err));

         if (!r_rst) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_err = 1'b0;
         end else begin
            acc = r_ie && e_rdy && (r_iid != 4'h0);
            dec = r_we && (r_wid != 4'h0) && (m_cnt[r_wid] > 0);
            if (r_we && r_wid != 4'h0 && m_cnt[r_wid] == 0) m_err = 1'b1;
            if (acc) m_cnt[r_iid] = m_cnt[r_iid] + 1;
            if (dec) m_cnt[r_wid] = m_cnt[r_wid] - 1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
